// File: rtl/pcpi_rr_arbiter_pkg.sv
// pcpi_arb_pkg: shared definitions for the PCPI round-robin arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, BUSY, RESP)
//   - PCPI_INSN_W : instruction width on the PCPI port
//   - PCPI_DATA_W : result width on the PCPI port
//   - clog2()     : id-width helper usable in constant expressions
package pcpi_arb_pkg;

    localparam int PCPI_INSN_W = 32;
    localparam int PCPI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Smallest r with 2**r >= n (0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pcpi_rr_arbiter_if.sv
// pcpi_rr_arbiter_if: PCPI handshake bundle between the arbiter and the
// fused matrix-multiply coprocessor.
//   pcpi_valid  master->slave  instruction valid
//   pcpi_insn   master->slave  instruction word
//   pcpi_ready  slave->master  coprocessor done
//   pcpi_wr     slave->master  coprocessor writes rd
//   pcpi_rd     slave->master  coprocessor result
//   pcpi_wait   slave->master  coprocessor still working
// Modports: master (arbiter side), slave (coprocessor side).
interface pcpi_rr_arbiter_if;
    import pcpi_arb_pkg::*;

    logic                   pcpi_valid;
    logic [PCPI_INSN_W-1:0] pcpi_insn;
    logic                   pcpi_ready;
    logic                   pcpi_wr;
    logic [PCPI_DATA_W-1:0] pcpi_rd;
    logic                   pcpi_wait;

    modport master (
        output pcpi_valid, pcpi_insn,
        input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait
    );

    modport slave (
        input  pcpi_valid, pcpi_insn,
        output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait
    );

endinterface

// File: rtl/pcpi_rr_arbiter_pick.sv
// rr_pick: combinational round-robin selector.
//   req   in   NREQ   request vector
//   last  in   id     index of the previous winner
//   found out  1      at least one request is set
//   win   out  id     first set index strictly after last, wrapping
module rr_pick
    import pcpi_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic                   found,
    output logic [clog2(NREQ)-1:0] win
);
    localparam int ID_W = clog2(NREQ);

    // Two passes: indices above last first, then wrap to the lowest index
    // at or below last. The lowest hit inside each pass wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (ID_W'(i) > last)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (ID_W'(i) <= last)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pcpi_rr_arbiter.sv
// pcpi_rr_arbiter: round-robin arbiter sharing one PCPI coprocessor among
// NREQ instruction requesters. Latches the winning instruction, drives the
// PCPI handshake, and returns the result as a one-cycle completion pulse.
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/insn    per-requester instruction request (32 bits each)
//   req_ready/err     one-hot completion / abort pulse to the winner
//   req_wr/rd         captured coprocessor result, valid with req_ready
//   busy, grant_id    activity flag and current/last winner index
//   pcpi              PCPI master port (pcpi_rr_arbiter_if.master)
// Optional feature: define PCPI_ARB_WATCHDOG_EN to enable the BUSY-state
// watchdog (TIMEOUT_CYC idle coprocessor cycles abort with req_err).
module pcpi_rr_arbiter
    import pcpi_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [PCPI_INSN_W*NREQ-1:0] req_insn,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             req_err,
    output logic                        req_wr,
    output logic [PCPI_DATA_W-1:0]      req_rd,
    output logic                        busy,
    output logic [clog2(NREQ)-1:0]      grant_id,
    pcpi_rr_arbiter_if.master           pcpi
);
    localparam int ID_W = clog2(NREQ);

    arb_state_e             state;
    logic [ID_W-1:0]        last_id;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [PCPI_INSN_W-1:0] pick_insn;
    logic [NREQ-1:0]        grant_onehot;
    logic                   wd_expire;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .last  (last_id),
        .found (pick_found),
        .win   (pick_id)
    );

    always_comb begin
        pick_insn    = '0;
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == ID_W'(i)) pick_insn = req_insn[PCPI_INSN_W*i +: PCPI_INSN_W];
            grant_onehot[i] = (grant_id == ID_W'(i));
        end
    end

`ifdef PCPI_ARB_WATCHDOG_EN
    localparam int WD_W = clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_tick;

    // Only cycles where the coprocessor neither works nor answers count.
    assign wd_tick   = !pcpi.pcpi_wait && !pcpi.pcpi_ready;
    assign wd_expire = (state == BUSY) && wd_tick && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            req_err <= '0;
        end else begin
            req_err <= '0;
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (state == BUSY && wd_tick) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) req_err <= grant_onehot;
        end
    end
`else
    logic unused_wd;

    assign wd_expire = 1'b0;
    assign req_err   = '0;
    assign unused_wd = ^{pcpi.pcpi_wait, TIMEOUT_CYC};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_id         <= ID_W'(NREQ - 1);
            grant_id        <= '0;
            busy            <= 1'b0;
            pcpi.pcpi_valid <= 1'b0;
            pcpi.pcpi_insn  <= '0;
            req_ready       <= '0;
            req_rd          <= '0;
            req_wr          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id        <= pick_id;
                        pcpi.pcpi_insn  <= pick_insn;
                        pcpi.pcpi_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    // A real answer takes priority over a same-cycle timeout.
                    if (pcpi.pcpi_ready) begin
                        pcpi.pcpi_valid <= 1'b0;
                        req_ready       <= grant_onehot;
                        req_rd          <= pcpi.pcpi_rd;
                        req_wr          <= pcpi.pcpi_wr;
                        state           <= RESP;
                    end else if (wd_expire) begin
                        pcpi.pcpi_valid <= 1'b0;
                        req_ready       <= grant_onehot;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= '0;
                    req_rd    <= '0;
                    req_wr    <= 1'b0;
                    last_id   <= grant_id;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_rr_arbiter.sv
// tb_pcpi_rr_arbiter: self-checking bench for pcpi_rr_arbiter with a
// transaction-level reference model, directed scenarios and random traffic.
module tb_pcpi_rr_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 8;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_insn;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_err;
    logic                 req_wr;
    logic [31:0]          req_rd;
    logic                 busy;
    logic [IDW-1:0]       grant_id;

    pcpi_rr_arbiter_if u_if ();

    pcpi_rr_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_insn  (req_insn),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_wr    (req_wr),
        .req_rd    (req_rd),
        .busy      (busy),
        .grant_id  (grant_id),
        .pcpi      (u_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state (transaction view)
    int              m_st;     // 0 waiting, 1 coprocessor working, 2 answering
    int              m_last;
    int              m_gid;
    int              m_wd;
    logic            exp_valid;
    logic [31:0]     exp_insn;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_err;
    logic [31:0]     exp_rd;
    logic            exp_wr;
    logic            exp_busy;

    // Stimulus controls
    int          cop_mode;  // 0 random, 1 fixed delay
    int          cop_d;     // ready after this many valid cycles (0 = never)
    logic [31:0] cop_rd;
    logic        cop_wr;
    logic        cop_wait;
    int          vcnt;
    bit          hold_all;
    bit          chk_starve;
    int          age [NREQ];
    int          served [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int q [$];
        for (int k = 1; k <= NREQ; k++) q.push_back((last + k) % NREQ);
        foreach (q[j]) if (v[q[j]]) return q[j];
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_last = NREQ - 1; m_gid = 0; m_wd = 0;
        exp_valid = 0; exp_insn = '0; exp_ready = '0; exp_err = '0;
        exp_rd = '0; exp_wr = 0; exp_busy = 0;
    endtask

    // Advance the model across the coming edge using the inputs now driven.
    task automatic predict();
        int w;
        exp_ready = '0; exp_err = '0; exp_rd = '0; exp_wr = 0;
        case (m_st)
            0: begin
                w = pick(req_valid, m_last);
                if (w >= 0) begin
                    m_gid = w; exp_insn = req_insn[32*w +: 32];
                    exp_valid = 1; m_wd = 0; m_st = 1;
                end
            end
            1: begin
                if (u_if.pcpi_ready) begin
                    exp_valid = 0; exp_ready[m_gid] = 1'b1;
                    exp_rd = u_if.pcpi_rd; exp_wr = u_if.pcpi_wr; m_st = 2;
                end
`ifdef PCPI_ARB_WATCHDOG_EN
                else begin
                    if (!u_if.pcpi_wait) m_wd++;
                    if (m_wd >= TO) begin
                        exp_valid = 0; exp_ready[m_gid] = 1'b1;
                        exp_err[m_gid] = 1'b1; m_st = 2;
                    end
                end
`endif
            end
            default: begin
                m_last = m_gid; m_st = 0;
            end
        endcase
        exp_busy = (m_st != 0);
    endtask

    task automatic check_all();
        chk("pcpi_valid", 64'(u_if.pcpi_valid), 64'(exp_valid));
        chk("pcpi_insn",  64'(u_if.pcpi_insn),  64'(exp_insn));
        chk("req_ready",  64'(req_ready),       64'(exp_ready));
        chk("req_err",    64'(req_err),         64'(exp_err));
        chk("req_rd",     64'(req_rd),          64'(exp_rd));
        chk("req_wr",     64'(req_wr),          64'(exp_wr));
        chk("busy",       64'(busy),            64'(exp_busy));
        chk("grant_id",   64'(grant_id),        64'(m_gid));
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                served.push_back(i);
                if (chk_starve && req_valid[i])
                    chk("starve_bound", 64'(age[i] <= NREQ - 1), 64'(1));
                age[i] = 0;
            end else if (|req_ready && req_valid[i]) begin
                age[i]++;
            end
        end
        if (!hold_all) req_valid = req_valid & ~req_ready;
        if (u_if.pcpi_valid) vcnt++; else vcnt = 0;
        if (cop_mode == 0) begin
            u_if.pcpi_ready = ($urandom_range(0, 2) == 0);
            u_if.pcpi_wr    = 1'($urandom);
            u_if.pcpi_rd    = $urandom;
            u_if.pcpi_wait  = 1'($urandom);
        end else begin
            u_if.pcpi_ready = (cop_d != 0) && (vcnt == cop_d);
            u_if.pcpi_wr    = cop_wr;
            u_if.pcpi_rd    = cop_rd;
            u_if.pcpi_wait  = cop_wait;
        end
    endtask

    task automatic wait_ready(input string tag, output int who);
        int guard;
        guard = 0;
        who = -1;
        do begin
            tick();
            guard++;
        end while (req_ready == '0 && guard < 40);
        chk({tag, "_done"}, 64'(|req_ready), 64'(1));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) who = i;
    endtask

    initial begin
        int who;
        int c0;
        int guard;
        rst = 1'b1;
        req_valid = '0; req_insn = '0;
        u_if.pcpi_ready = 0; u_if.pcpi_wr = 0; u_if.pcpi_rd = '0; u_if.pcpi_wait = 0;
        cop_mode = 1; cop_d = 0; cop_rd = '0; cop_wr = 0; cop_wait = 0; vcnt = 0;
        hold_all = 0; chk_starve = 0;
        foreach (age[i]) age[i] = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst = 1'b0;

        // Fairness: all four held, expect 0,1,2,3,0
        hold_all = 1;
        for (int i = 0; i < NREQ; i++) req_insn[32*i +: 32] = 32'h100 + i;
        req_valid = 4'b1111; cop_d = 2; cop_rd = 32'hA5; cop_wr = 1;
        guard = 0;
        while (served.size() < 5 && guard < 80) begin
            tick();
            guard++;
        end
        hold_all = 0; req_valid = '0;
        chk("fair_count", 64'(served.size()), 64'(5));
        for (int k = 0; k < 5 && k < served.size(); k++)
            chk("fair_order", 64'(served[k]), 64'(k % NREQ));

        // Contention after a win: 2 served, then 0101 -> 0 before 2
        req_valid = 4'b0100;
        wait_ready("cont_a", who);
        chk("cont_first", 64'(who), 64'(2));
        req_valid = 4'b0101;
        wait_ready("cont_b", who);
        chk("cont_next", 64'(who), 64'(0));
        wait_ready("cont_c", who);
        chk("cont_last", 64'(who), 64'(2));

        // Single request, coprocessor ready after 5 cycles
        tick(); tick();
        req_insn[31:0] = 32'h0000_0C0B; req_valid = 4'b0001;
        cop_d = 5; cop_rd = 32'h1234; cop_wr = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("single_valid", 64'(u_if.pcpi_valid), 64'(1));
            chk("single_ready_low", 64'(req_ready), 64'(0));
        end
        chk("single_insn", 64'(u_if.pcpi_insn), 64'h0C0B);
        tick();
        chk("single_ready", 64'(req_ready), 64'(4'b0001));
        chk("single_rd", 64'(req_rd), 64'h1234);
        chk("single_wr", 64'(req_wr), 64'(1));

        // Immediate ready
        tick();
        req_valid = 4'b0010; cop_d = 1; cop_rd = 32'h77; cop_wr = 0;
        tick();
        chk("imm_valid", 64'(u_if.pcpi_valid), 64'(1));
        tick();
        chk("imm_ready", 64'(req_ready), 64'(4'b0010));
        chk("imm_busy_resp", 64'(busy), 64'(1));
        tick();
        chk("imm_idle", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of BUSY
        hold_all = 1;
        for (int i = 0; i < NREQ; i++) req_insn[32*i +: 32] = 32'h200 + i;
        req_valid = 4'b1111; cop_d = 0;
        tick();
        chk("rst_pre_grant", 64'(grant_id), 64'(2));
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(u_if.pcpi_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(u_if.pcpi_valid), 64'(0));
        #3 rst = 1'b0;
        model_reset();
        vcnt = 0; cop_d = 3;
        tick();
        chk("rst_first_grant", 64'(grant_id), 64'(0));
        chk("rst_first_insn", 64'(u_if.pcpi_insn), 64'h200);
        hold_all = 0; req_valid = '0;
        wait_ready("rst_done", who);
        chk("rst_winner", 64'(who), 64'(0));
        tick();

`ifdef PCPI_ARB_WATCHDOG_EN
        // Watchdog: silent coprocessor times out 9 cycles after grant
        cop_d = 0; cop_wait = 0; cop_rd = 32'hDEAD; cop_wr = 1;
        req_valid = 4'b0100;
        c0 = cyc;
        wait_ready("wd", who);
        chk("wd_latency", 64'(cyc - c0), 64'(9));
        chk("wd_err", 64'(req_err), 64'(4'b0100));
        chk("wd_rd", 64'(req_rd), 64'(0));
        tick();
        // Working coprocessor never times out
        cop_wait = 1;
        req_valid = 4'b0100;
        for (int k = 0; k < 30; k++) tick();
        chk("wd_wait_busy", 64'(busy), 64'(1));
        cop_d = vcnt + 1;
        wait_ready("wd_wait", who);
        chk("wd_wait_err", 64'(req_err), 64'(0));
        cop_wait = 0;
        tick();
`else
        c0 = 0;
`endif

        // Random traffic
        cop_mode = 0; chk_starve = 1;
        foreach (age[i]) age[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_insn[32*i +: 32] = $urandom;
                    age[i] = 0;
                end
            end
            if (busy && u_if.pcpi_valid && $urandom_range(0, 15) == 0)
                req_valid[grant_id] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcpi_rr_arbiter.md
# pcpi_rr_arbiter

Round-robin arbiter sharing one PCPI coprocessor (the fused matrix-multiply unit) among NREQ instruction requesters, such as the serial instruction loader and an on-chip test sequencer. It latches the winning instruction, drives the PCPI handshake to the coprocessor, and returns the result to the winner as a one-cycle completion pulse. It sits between the requester front-ends and the coprocessor's PCPI port.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has an instruction pending
- req_insn  in  32*NREQ  instruction of requester i, in bits [32*i+31:32*i]
- req_ready  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- req_err  out  NREQ  one-hot, one-cycle abort pulse, coincident with req_ready
- req_wr  out  1  captured pcpi_wr, valid while any req_ready bit is high
- req_rd  out  32  captured pcpi_rd, valid while any req_ready bit is high
- busy  out  1  high in BUSY and RESP
- grant_id  out  clog2(NREQ)  index of the current or last winner
- pcpi_valid  out  1  instruction valid to the coprocessor
- pcpi_insn  out  32  latched instruction
- pcpi_ready  in  1  coprocessor done
- pcpi_wr  in  1  coprocessor writes rd
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor still working

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req_valid bit is high, pick the first set index strictly after the last winner, wrapping modulo NREQ. Latch the instruction into pcpi_insn and the index into grant_id, then go to BUSY.
- BUSY: pcpi_valid is held at 1. When pcpi_ready is sampled high, capture pcpi_wr and pcpi_rd, clear pcpi_valid, and go to RESP.
- RESP: assert req_ready[grant_id] for one cycle and set the last-winner pointer to grant_id. Go to IDLE.
- Requesters hold req_valid and req_insn until they see their req_ready.
- If the winner drops req_valid during BUSY, the arbiter ignores it. The transaction completes and the ready pulse is still issued.
- pcpi_ready, pcpi_wr and pcpi_rd are ignored in IDLE and RESP.
- req_rd and req_wr read 0 whenever req_ready is all zero.
- Reset values of outputs:
  - pcpi_valid=0, pcpi_insn=0
  - req_ready=0, req_err=0, req_rd=0, req_wr=0
  - busy=0, grant_id=0
  - last-winner pointer = NREQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts at once to IDLE with no completion pulse. The coprocessor is reset by the same system reset.

## Timing
- Cycle 0: req_valid seen in IDLE. Cycle 1: pcpi_valid=1 and pcpi_insn is stable.
- pcpi_ready sampled high in cycle k puts req_ready high in cycle k+1. The arbiter is back in IDLE in cycle k+2.
- Minimum request-to-ready latency is 2 cycles (coprocessor ready in cycle 1).
- Maximum throughput is one instruction per 3 cycles.
- A request arriving during BUSY or RESP waits. The winner is evaluated only in IDLE, so a request arriving in the RESP cycle competes at the next IDLE.
- Starvation bound: a held request is served within NREQ grants.

## Configuration
- Macro PCPI_ARB_WATCHDOG_EN, defined:
  - A counter clears on entry to BUSY and increments on each BUSY cycle with pcpi_wait=0 and pcpi_ready=0.
  - On reaching TIMEOUT_CYC, the arbiter drops pcpi_valid and goes to RESP. It pulses req_ready[id] and req_err[id] together, with req_rd=0 and req_wr=0.
  - If pcpi_ready and the timeout occur in the same cycle, pcpi_ready wins.
- Macro undefined: no counter, req_err is tied 0, and BUSY waits indefinitely.

## Structure
- Package pcpi_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - PCPI_INSN_W=32 and PCPI_DATA_W=32
  - an id-width function clog2
- Sub-module rr_pick is purely combinational. Inputs: request vector and last-winner index. Outputs: found flag and winner index.

## Test plan
- Single request: req_valid=0001, insn 0x0000_0C0B, coprocessor ready after 5 cycles with rd=0x1234 and wr=1 -> pcpi_valid high for cycles 1..5, req_ready=0001 in cycle 6 with req_rd=0x1234 and req_wr=1.
- Fairness: req_valid=1111 held across four completions -> grant order 0,1,2,3, then wraps to 0.
- Contention after a win: requester 2 is served last, then req_valid=0101 -> next grant is 0, not 2.
- Immediate ready: pcpi_ready high in cycle 1 -> req_ready in cycle 2, IDLE in cycle 3.
- Async reset mid-BUSY: rst pulsed in cycle 3 -> pcpi_valid=0 immediately, no req_ready pulse, and the first grant after reset goes to requester 0.
- Watchdog (macro defined, TIMEOUT_CYC=8): pcpi_wait=0 and pcpi_ready never asserted -> req_ready and req_err pulse for the winner 9 cycles after grant, with req_rd=0. Repeat with pcpi_wait=1 held -> no timeout.
